mem_access_ctrl: RTL and testbench

- Initiator side of the word-wide, single-read/single-write data memory (registered read, 1-cycle read latency, no byte enables).
- Accepts byte/half/word load and store requests from the core over a valid/ready request channel and returns results on a valid/ready response channel.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- Memory is big-endian: byte offset 0 maps to bits [31:24].

---
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide, big-endian, 1-cycle-latency data memory; sub-word stores use read-modify-write.
// Optional build macro MEM_ACC_CHECK_EN: report misaligned / out-of-range requests on o_rsp_err instead of force-aligning.
module mem_access_ctrl #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_req_err;
  logic [7:0]            w_lane_byte;
  logic [15:0]           w_lane_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

`ifdef MEM_ACC_CHECK_EN
  always_comb begin
    w_req_err = 1'b0;
    if (i_req_size == 2'b01 && i_req_addr[0])
      w_req_err = 1'b1;
    if (i_req_size[1] && i_req_addr[1:0] != 2'b00)
      w_req_err = 1'b1;
    if (i_req_addr >= ADDR_WIDTH'(MEM_SIZE))
      w_req_err = 1'b1;
  end
`else
  assign w_req_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_req_err)
            w_next = RESP;
          else if (i_req_we && i_req_size[1])
            w_next = WR;
          else
            w_next = RD;
        end
      end
      RD:      w_next = RD_DATA;
      RD_DATA: w_next = r_we ? WR : RESP;
      WR: begin
        o_mem_we = ~i_rst;
        w_next   = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Big-endian lanes: byte offset 0 is the most significant byte; half lane picked by addr[1] only.
  always_comb begin
    w_lane_byte = 8'h00;
    w_merged    = i_mem_rdata;
    case (r_addr[1:0])
      2'd0: begin w_lane_byte = i_mem_rdata[31:24]; w_merged[31:24] = r_wdata[7:0]; end
      2'd1: begin w_lane_byte = i_mem_rdata[23:16]; w_merged[23:16] = r_wdata[7:0]; end
      2'd2: begin w_lane_byte = i_mem_rdata[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
      default: begin w_lane_byte = i_mem_rdata[7:0]; w_merged[7:0] = r_wdata[7:0]; end
    endcase
    w_lane_half = r_addr[1] ? i_mem_rdata[15:0] : i_mem_rdata[31:16];
    w_load      = i_mem_rdata;
    if (r_size == 2'b00) begin
      w_load = r_unsigned ? {24'h000000, w_lane_byte} : {{24{w_lane_byte[7]}}, w_lane_byte};
    end else if (r_size == 2'b01) begin
      w_load   = r_unsigned ? {16'h0000, w_lane_half} : {{16{w_lane_half[15]}}, w_lane_half};
      w_merged = i_mem_rdata;
      if (r_addr[1])
        w_merged[15:0] = r_wdata[15:0];
      else
        w_merged[31:16] = r_wdata[15:0];
    end
  end

  // r_wdata doubles as the merged write word once the read half of a read-modify-write returns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rdata    <= '0;
            r_err      <= w_req_err;
          end
        end
        RD_DATA: begin
          if (r_we)
            r_wdata <= w_merged;
          else
            r_rdata <= w_load;
        end
        WR:      r_rdata <= '0;
        default: ;
      endcase
    end
  end

  assign o_mem_raddr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_waddr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata = r_wdata;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural registered-read memory.
// Error-path vectors switch on MEM_ACC_CHECK_EN to match the build of the DUT.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        memWe;
  logic [31:0] memRaddr;
  logic [31:0] memWaddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  logic [31:0] mem [0:1023];
  logic        bdWe;
  logic [31:0] bdAddr;
  logic [31:0] bdData;

  int          passCount;
  int          checkCount;
  int          lastLat;
  int          lastWeCount;
  int          lastWeFirst;
  logic [31:0] lastWaddr;
  logic [31:0] lastWdata;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic [31:0] heldRdata;

  mem_access_ctrl #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (reqValid),
    .o_req_ready    (reqReady),
    .i_req_we       (reqWe),
    .i_req_size     (reqSize),
    .i_req_unsigned (reqUnsigned),
    .i_req_addr     (reqAddr),
    .i_req_wdata    (reqWdata),
    .o_rsp_valid    (rspValid),
    .i_rsp_ready    (rspReady),
    .o_rsp_rdata    (rspRdata),
    .o_rsp_err      (rspErr),
    .o_mem_we       (memWe),
    .o_mem_raddr    (memRaddr),
    .o_mem_waddr    (memWaddr),
    .o_mem_wdata    (memWdata),
    .i_mem_rdata    (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide memory: registered read, write on mem_we, plus a backdoor port for preloading.
  always @(posedge clk) begin
    memRdata <= mem[memRaddr[11:2]];
    if (memWe)
      mem[memWaddr[11:2]] <= memWdata;
    else if (bdWe)
      mem[bdAddr[11:2]] <= bdData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  task automatic backdoorWrite(input logic [31:0] addr, input logic [31:0] data);
    bdWe = 1'b1; bdAddr = addr; bdData = data;
    @(posedge clk); #1;
    bdWe = 1'b0;
  endtask

  // Issues one request and follows it until rsp_valid, recording latency and any write pulses.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    checkOutput({tag, " reqReadyBeforeAccept"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWe = we; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lastWeCount = 0; lastWeFirst = 0; lastWaddr = '0; lastWdata = '0;
    for (int c = 1; c <= 20; c++) begin
      lastLat = c;
      if (memWe) begin
        lastWeCount++;
        if (lastWeFirst == 0) lastWeFirst = c;
        lastWaddr = memWaddr;
        lastWdata = memWdata;
      end
      if (rspValid) break;
      @(posedge clk); #1;
    end
    lastRdata = rspRdata;
    lastErr   = rspErr;
  endtask

  task automatic expectResponse(input string tag, input int expLat, input logic [31:0] expRdata,
                                input logic expErr, input int expWeCount);
    checkOutput({tag, " latency"}, 32'(lastLat), 32'(expLat));
    checkOutput({tag, " rdata"}, lastRdata, expRdata);
    checkOutput({tag, " err"}, 32'(lastErr), 32'(expErr));
    checkOutput({tag, " weCount"}, 32'(lastWeCount), 32'(expWeCount));
  endtask

  task automatic finishResponse(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, " reqReadyAfterHandshake"}, 32'(reqReady), 32'd1);
    checkOutput({tag, " rspValidAfterHandshake"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    passCount = 0; checkCount = 0;
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = '0; reqWdata = '0; rspReady = 1'b1;
    bdWe = 1'b0; bdAddr = '0; bdData = '0;

    backdoorWrite(32'h0000_0000, 32'h5A5A5A5A);
    backdoorWrite(32'h0000_0010, 32'h80FF7F01);
    backdoorWrite(32'h0000_0020, 32'h11223344);
    backdoorWrite(32'h0000_0028, 32'h00000000);
    checkOutput("reset reqReady", 32'(reqReady), 32'd1);
    checkOutput("reset rspValid", 32'(rspValid), 32'd0);
    checkOutput("reset rspRdata", rspRdata, 32'h0);
    checkOutput("reset rspErr", 32'(rspErr), 32'd0);
    checkOutput("reset memWe", 32'(memWe), 32'd0);
    checkOutput("reset memRaddr", memRaddr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("LB 0x10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    expectResponse("LB 0x10", 3, 32'hFFFFFF80, 1'b0, 0);
    finishResponse("LB 0x10");
    applyStimulus("LBU 0x11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    expectResponse("LBU 0x11", 3, 32'h000000FF, 1'b0, 0);
    finishResponse("LBU 0x11");
    applyStimulus("LBU 0x13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    expectResponse("LBU 0x13", 3, 32'h00000001, 1'b0, 0);
    finishResponse("LBU 0x13");
    applyStimulus("LH 0x12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    expectResponse("LH 0x12", 3, 32'h00007F01, 1'b0, 0);
    finishResponse("LH 0x12");
    applyStimulus("LH 0x10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    expectResponse("LH 0x10", 3, 32'hFFFF80FF, 1'b0, 0);
    finishResponse("LH 0x10");

    applyStimulus("SB 0x22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AB);
    expectResponse("SB 0x22", 4, 32'h0, 1'b0, 1);
    checkOutput("SB 0x22 waddr", lastWaddr, 32'h20);
    checkOutput("SB 0x22 wdata", lastWdata, 32'h1122AB44);
    finishResponse("SB 0x22");
    checkOutput("SB 0x22 memWord", mem[8], 32'h1122AB44);
    applyStimulus("SH 0x20", 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF);
    expectResponse("SH 0x20", 4, 32'h0, 1'b0, 1);
    checkOutput("SH 0x20 wdata", lastWdata, 32'hBEEFAB44);
    finishResponse("SH 0x20");
    checkOutput("SH 0x20 memWord", mem[8], 32'hBEEFAB44);
    applyStimulus("SW 0x24", 1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D);
    expectResponse("SW 0x24", 2, 32'h0, 1'b0, 1);
    checkOutput("SW 0x24 weFirst", 32'(lastWeFirst), 32'd1);
    checkOutput("SW 0x24 waddr", lastWaddr, 32'h24);
    finishResponse("SW 0x24");
    checkOutput("SW 0x24 memWord", mem[9], 32'hCAFEF00D);

    rspReady = 1'b0;
    applyStimulus("BP LB 0x10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    expectResponse("BP LB 0x10", 3, 32'hFFFFFF80, 1'b0, 0);
    heldRdata = rspRdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("BP rspValid held", 32'(rspValid), 32'd1);
      checkOutput("BP rspRdata held", rspRdata, heldRdata);
      checkOutput("BP reqReady low", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    finishResponse("BP release");

`ifdef MEM_ACC_CHECK_EN
    applyStimulus("LW 0x12 err", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    expectResponse("LW 0x12 err", 1, 32'h0, 1'b1, 0);
    finishResponse("LW 0x12 err");
    applyStimulus("SB 0x1000 err", 1'b1, 2'b00, 1'b0, 32'h1000, 32'h000000EE);
    expectResponse("SB 0x1000 err", 1, 32'h0, 1'b1, 0);
    finishResponse("SB 0x1000 err");
    checkOutput("SB 0x1000 mem0", mem[0], 32'h5A5A5A5A);
`else
    applyStimulus("LW 0x12 aligned", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    expectResponse("LW 0x12 aligned", 3, 32'h80FF7F01, 1'b0, 0);
    finishResponse("LW 0x12 aligned");
`endif

    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0; reqAddr = 32'h21; reqWdata = 32'h77;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("RST SB memWe in RD_DATA", 32'(memWe), 32'd0);
    @(posedge clk); #1;
    checkOutput("RST SB reqReady", 32'(reqReady), 32'd1);
    checkOutput("RST SB rspValid", 32'(rspValid), 32'd0);
    checkOutput("RST SB memWe", 32'(memWe), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("RST SB memWe after", 32'(memWe), 32'd0);
    end
    checkOutput("RST SB memWord", mem[8], 32'hBEEFAB44);

    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'b10; reqAddr = 32'h28; reqWdata = 32'h12345678;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("RST WR memWe before", 32'(memWe), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("RST WR memWe gated", 32'(memWe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("RST WR reqReady", 32'(reqReady), 32'd1);
    checkOutput("RST WR rspValid", 32'(rspValid), 32'd0);
    checkOutput("RST WR memWord", mem[10], 32'h00000000);

    applyStimulus("SW 0x30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF);
    expectResponse("SW 0x30", 2, 32'h0, 1'b0, 1);
    finishResponse("SW 0x30");
    applyStimulus("LW 0x30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    expectResponse("LW 0x30", 3, 32'hDEADBEEF, 1'b0, 0);
    finishResponse("LW 0x30");
    applyStimulus("LW size11 0x30", 1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    expectResponse("LW size11 0x30", 3, 32'hDEADBEEF, 1'b0, 0);
    finishResponse("LW size11 0x30");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
